// File: rtl/color_mapping_mul_pipe.sv
// Unsigned multiply with optional rounded right shift, saturation and an elastic
// NUM_STAGE-deep valid/ready pipeline. Optional build macro: COLOR_MAPPING_MUL_ROUND_EN.
module color_mapping_mul_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 2,
  parameter int din0_WIDTH = 37,
  parameter int din1_WIDTH = 6,
  parameter int dout_WIDTH = 43,
  parameter int SHIFT      = 0
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_sat
);

  localparam int PW = din0_WIDTH + din1_WIDTH;
  localparam int RW = PW + 1;

  if (NUM_STAGE < 1 || NUM_STAGE > 4 || SHIFT < 0 || SHIFT >= PW || ID < 0) begin : g_param_check
    $error("color_mapping_mul_pipe: illegal parameter value");
  end

  logic                         ce;
  logic [PW-1:0]                prod;
  logic [RW-1:0]                res;
  logic [RW+dout_WIDTH-1:0]     res_ext;
  logic                         res_sat;
  logic [dout_WIDTH-1:0]        res_dout;
  logic [NUM_STAGE-1:0]         vld;
  logic [NUM_STAGE-1:0]         sat;
  logic [dout_WIDTH-1:0]        dat [NUM_STAGE];

  assign ce       = out_ready || !out_valid;
  assign in_ready = ap_rst_n && ce;
  assign prod     = PW'(din0) * PW'(din1);

`ifdef COLOR_MAPPING_MUL_ROUND_EN
  // One spare bit above the product keeps the half-LSB addition from wrapping.
  if (SHIFT > 0) begin : g_round
    assign res = (RW'(prod) + (RW'(1) << (SHIFT - 1))) >> SHIFT;
  end else begin : g_trunc
    assign res = RW'(prod) >> SHIFT;
  end
`else
  assign res = RW'(prod) >> SHIFT;
`endif

  // Zero-extended copy lets dout_WIDTH be wider or narrower than the result.
  assign res_ext  = {{dout_WIDTH{1'b0}}, res};
  assign res_sat  = |(res_ext >> dout_WIDTH);
  assign res_dout = res_sat ? '1 : res_ext[dout_WIDTH-1:0];

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      vld <= '0;
      sat <= '0;
      for (int unsigned i = 0; i < NUM_STAGE; i++) dat[i] <= '0;
    end else if (ce) begin
      vld[0] <= in_valid;
      sat[0] <= res_sat;
      dat[0] <= res_dout;
      for (int unsigned i = 1; i < NUM_STAGE; i++) begin
        vld[i] <= vld[i-1];
        sat[i] <= sat[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[NUM_STAGE-1];
  assign dout_sat  = sat[NUM_STAGE-1];
  assign dout      = dat[NUM_STAGE-1];

endmodule

// File: tb/tb_color_mapping_mul_pipe.sv
// Scoreboard bench: three 37x6 instances (2, 1, 4 stages) plus a narrow 8x6 SHIFT=4 instance.
module tb_color_mapping_mul_pipe;

  localparam int N = 3;
  localparam int STG [N] = '{2, 1, 4};

  typedef struct packed {
    logic [42:0] d;
    logic        s;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv [N];
  logic        ir [N];
  logic        ov [N];
  logic        ordy [N];
  logic        sat [N];
  logic [36:0] a [N];
  logic [5:0]  b [N];
  logic [42:0] d [N];

  logic       iv8, ir8, ov8, ordy8, sat8;
  logic [7:0] a8, d8;
  logic [5:0] b8;

  exp_t        sb [N][$];
  logic        stalled [N];
  logic [42:0] dhold [N];
  logic        shold [N];

  int checks = 0;
  int failures = 0;

  color_mapping_mul_pipe #(.NUM_STAGE(2)) u_s2 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .din0(a[0]), .din1(b[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .dout(d[0]), .dout_sat(sat[0]));

  color_mapping_mul_pipe #(.NUM_STAGE(1)) u_s1 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .din0(a[1]), .din1(b[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .dout(d[1]), .dout_sat(sat[1]));

  color_mapping_mul_pipe #(.NUM_STAGE(4)) u_s4 (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .din0(a[2]), .din1(b[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .dout(d[2]), .dout_sat(sat[2]));

  color_mapping_mul_pipe #(.NUM_STAGE(2), .din0_WIDTH(8), .din1_WIDTH(6),
                           .dout_WIDTH(8), .SHIFT(4)) u_small (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .din0(a8), .din1(b8), .out_valid(ov8), .out_ready(ordy8),
    .dout(d8), .dout_sat(sat8));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Transfers are decided at the coming posedge; inputs change only #1 after posedge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        sb[k].delete();
        stalled[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        check($sformatf("in_ready_%0d", k), ir[k], ordy[k] || !ov[k]);
        if (stalled[k]) begin
          check($sformatf("hold_valid_%0d", k), ov[k], 1);
          check($sformatf("hold_dout_%0d", k), d[k], dhold[k]);
          check($sformatf("hold_sat_%0d", k), sat[k], shold[k]);
        end
        stalled[k] = ov[k] && !ordy[k];
        dhold[k]   = d[k];
        shold[k]   = sat[k];
        if (iv[k] && ir[k]) begin
          exp_t e;
          e.d = 43'(a[k]) * 43'(b[k]);
          e.s = 1'b0;
          sb[k].push_back(e);
        end
        if (ov[k] && ordy[k]) begin
          if (sb[k].size() == 0) begin
            check($sformatf("spurious_out_%0d", k), 1, 0);
          end else begin
            exp_t e;
            e = sb[k].pop_front();
            check($sformatf("dout_%0d", k), d[k], e.d);
            check($sformatf("sat_%0d", k), sat[k], e.s);
          end
        end
      end
    end
  end

  task automatic latency_test(input int k);
    int n;
    ordy[k] = 1'b1;
    iv[k] = 1'b1;
    a[k]  = 37'h1F_FFFF_FFFF;
    b[k]  = 6'd63;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    n = 1;
    while (!ov[k] && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check($sformatf("latency_%0d", k), n, STG[k]);
    check($sformatf("max_product_%0d", k), d[k], 43'd8658654068673);
    check($sformatf("max_sat_%0d", k), sat[k], 0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic present(input int k, input int unsigned cycles, inout int idx);
    logic [36:0] items [3];
    items = '{37'd5, 37'd6, 37'd7};
    for (int unsigned c = 0; c < cycles && idx < 3; c++) begin
      iv[k] = 1'b1;
      a[k]  = items[idx];
      b[k]  = 6'd2;
      @(negedge clk);
      if (ir[k]) idx++;
      @(posedge clk); #1;
    end
    iv[k] = 1'b0;
  endtask

  task automatic backpressure_test(input int k);
    int idx;
    idx = 0;
    ordy[k] = 1'b0;
    present(k, 6, idx);
    check($sformatf("bp_accepted_%0d", k), idx, (STG[k] < 3) ? STG[k] : 3);
    ordy[k] = 1'b1;
    present(k, 20, idx);
    check($sformatf("bp_all_in_%0d", k), idx, 3);
    repeat (8) @(posedge clk);
    #1;
    check($sformatf("bp_drain_%0d", k), sb[k].size(), 0);
  endtask

  task automatic small_case(input logic [7:0] x, input logic [5:0] y,
                            input logic [7:0] ed, input logic es);
    int n;
    iv8 = 1'b1;
    a8  = x;
    b8  = y;
    @(posedge clk); #1;
    iv8 = 1'b0;
    n = 1;
    while (!ov8 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("small_latency", n, 2);
    check("small_dout", d8, ed);
    check("small_sat", sat8, es);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    for (int k = 0; k < N; k++) begin
      iv[k] = 1'b0; a[k] = '0; b[k] = '0; ordy[k] = 1'b1;
    end
    iv8 = 1'b0; a8 = '0; b8 = '0; ordy8 = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_valid_%0d", k), ov[k], 0);
      check($sformatf("rst_dout_%0d", k), d[k], 0);
      check($sformatf("rst_sat_%0d", k), sat[k], 0);
      check($sformatf("rst_in_ready_%0d", k), ir[k], 0);
    end
    rst_n = 1'b1;
    #1;
    check("in_ready_after_rst", ir[0], 1);

    for (int k = 0; k < N; k++) latency_test(k);

    ordy[0] = 1'b1;
    for (int unsigned kk = 1; kk <= 10; kk++) begin
      iv[0] = 1'b1;
      a[0]  = 37'(kk);
      b[0]  = 6'(kk + 1);
      #1;
      check("b2b_in_ready", ir[0], 1);
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("b2b_drain", sb[0].size(), 0);

    for (int k = 0; k < N; k++) backpressure_test(k);

    ordy[0] = 1'b1;
    iv[0] = 1'b1; a[0] = 37'd100; b[0] = 6'd3;
    @(posedge clk); #1;
    a[0] = 37'd200;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_valid", ov[0], 0);
    check("midrst_dout", d[0], 0);
    n = 0;
    for (int c = 0; c < 5; c++) begin
      if (ov[0]) n++;
      @(posedge clk); #1;
    end
    check("midrst_no_stale", n, 0);
    iv[0] = 1'b1; a[0] = 37'd1234567; b[0] = 6'd45;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    n = 1;
    while (!ov[0] && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst_latency", n, 2);
    check("midrst_result", d[0], 43'd55555515);
    repeat (3) @(posedge clk);
    #1;

    small_case(8'd255, 6'd63, 8'd255, 1'b1);
`ifdef COLOR_MAPPING_MUL_ROUND_EN
    small_case(8'd3, 6'd3, 8'd1, 1'b0);
    small_case(8'd17, 6'd15, 8'd16, 1'b0);
`else
    small_case(8'd3, 6'd3, 8'd0, 1'b0);
    small_case(8'd17, 6'd15, 8'd15, 1'b0);
`endif
    small_case(8'd64, 6'd63, 8'd252, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
